// File: rtl/uart_pkg.sv
// Shared UART definitions: output-mux select encodings, transmitter FSM
// state encoding and the parity helper used when a byte is captured.
package uart_pkg;

  // Bit-type select driven to the downstream 4:1 serial output mux.
  typedef enum logic [1:0] {
    START_BIT  = 2'b00,
    DATA_BIT   = 2'b01,
    PARITY_BIT = 2'b10,
    STOP_BIT   = 2'b11
  } sel_t;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Widest data word the parity helper accepts; narrower words are
  // zero-extended, which leaves the XOR reduction unchanged.
  localparam int PARITY_MAX_W = 32;

  // Even parity is the plain XOR reduction; odd parity inverts it.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                       input logic                    odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts clk cycles within one serial bit and flags the last
// cycle of the bit. The counter wraps to zero on that last cycle and is held
// at zero while clear is asserted, so each new state starts a fresh bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter within the current bit; restarts on clear or bit end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear || bit_end) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bit_end = (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller. Sequences start, data (LSB first), parity and
// stop bits by steering the select of an external 4:1 output mux, and
// supplies the current data bit and the frame parity as mux inputs.
// DATA_WIDTH is limited to uart_pkg::PARITY_MAX_W bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [1:0]            sel,
  output logic                  data_bit,
  output logic                  parity_bit,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic             ODD_SEL  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  state_t                state_r;
  sel_t                  sel_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [IDX_W-1:0]      bit_idx_r;
  logic                  data_bit_r;
  logic                  parity_bit_r;
  logic                  tx_busy_r;
  logic                  tx_done_r;

  logic                  clear_s;
  logic                  bit_end_s;
  logic [DATA_WIDTH-1:0] shift_next_s;
  logic                  parity_next_s;

  // The bit timer idles at zero so the START bit gets a full bit period.
  assign clear_s = (state_r == ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_s),
    .bit_end(bit_end_s)
  );

  // Next shift-register contents and parity of the word offered on tx_data.
  always_comb begin
    shift_next_s  = shift_r >> 1;
    parity_next_s = calc_parity(PARITY_MAX_W'(tx_data), ODD_SEL);
  end

  // Frame sequencer: state, shift register, bit index and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sel_r        <= STOP_BIT;
      shift_r      <= {DATA_WIDTH{1'b0}};
      bit_idx_r    <= {IDX_W{1'b0}};
      data_bit_r   <= 1'b0;
      parity_bit_r <= 1'b0;
      tx_busy_r    <= 1'b0;
      tx_done_r    <= 1'b0;
    end else begin
      // tx_done is only raised on the STOP->IDLE edge below.
      tx_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (tx_start) begin
            shift_r      <= tx_data;
            parity_bit_r <= parity_next_s;
            bit_idx_r    <= {IDX_W{1'b0}};
            state_r      <= ST_START;
            sel_r        <= START_BIT;
            tx_busy_r    <= 1'b1;
          end else begin
            sel_r     <= STOP_BIT;
            tx_busy_r <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r    <= ST_DATA;
            sel_r      <= DATA_BIT;
            data_bit_r <= shift_r[0];
            bit_idx_r  <= {IDX_W{1'b0}};
          end else begin
            sel_r <= START_BIT;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            if (bit_idx_r == LAST_IDX) begin
              // Last data bit done; data_bit keeps its final value.
              state_r   <= ST_PARITY;
              sel_r     <= PARITY_BIT;
              bit_idx_r <= {IDX_W{1'b0}};
            end else begin
              shift_r    <= shift_next_s;
              data_bit_r <= shift_next_s[0];
              bit_idx_r  <= bit_idx_r + IDX_W'(1);
            end
          end else begin
            sel_r <= DATA_BIT;
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            state_r <= ST_STOP;
            sel_r   <= STOP_BIT;
          end else begin
            sel_r <= PARITY_BIT;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            state_r   <= ST_IDLE;
            sel_r     <= STOP_BIT;
            tx_busy_r <= 1'b0;
            tx_done_r <= 1'b1;
          end else begin
            sel_r <= STOP_BIT;
          end
        end
        default: begin
          // Unreachable encodings recover to a quiet line.
          state_r   <= ST_IDLE;
          sel_r     <= STOP_BIT;
          tx_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = sel_r;
  assign data_bit   = data_bit_r;
  assign parity_bit = parity_bit_r;
  assign tx_busy    = tx_busy_r;
  assign tx_done    = tx_done_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. Three instances: even parity and
// odd parity at 4 clocks/bit, and even parity at 2 clocks/bit. Expected
// frames go into a scoreboard queue when a frame is started and are popped
// when the transmitted frame has been reassembled from the DUT outputs.
module tb_uart_tx_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic clk;
  logic rst;

  logic       start0, start1, start2;
  logic [7:0] data0, data1, data2;
  logic [1:0] sel0, sel1, sel2;
  logic       db0, db1, db2;
  logic       pb0, pb1, pb2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  exp_t sb_q[$];
  int   tests_run;
  int   tests_failed;

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .tx_start(start0), .tx_data(data0), .sel(sel0),
    .data_bit(db0), .parity_bit(pb0), .tx_busy(busy0), .tx_done(done0));

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .tx_start(start1), .tx_data(data1), .sel(sel1),
    .data_bit(db1), .parity_bit(pb1), .tx_busy(busy1), .tx_done(done1));

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .PARITY_ODD(0)) u_fast (
    .clk(clk), .rst(rst), .tx_start(start2), .tx_data(data2), .sel(sel2),
    .data_bit(db2), .parity_bit(pb2), .tx_busy(busy2), .tx_done(done2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input int d, input logic st, input logic [7:0] dat);
    case (d)
      0: begin start0 = st; data0 = dat; end
      1: begin start1 = st; data1 = dat; end
      default: begin start2 = st; data2 = dat; end
    endcase
  endtask

  task automatic sample(input int d, output logic [1:0] s, output logic db,
                        output logic pb, output logic busy, output logic done);
    case (d)
      0: begin s = sel0; db = db0; pb = pb0; busy = busy0; done = done0; end
      1: begin s = sel1; db = db1; pb = pb1; busy = busy1; done = done1; end
      default: begin s = sel2; db = db2; pb = pb2; busy = busy2; done = done2; end
    endcase
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e.data = 8'hxx;
    e.par  = 1'bx;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    return e;
  endfunction

  // Offer a byte on dut d for one accepting edge and record the expected frame.
  // Unless held, tx_start drops and tx_data changes right after acceptance.
  task automatic start_frame(input int d, input logic [7:0] dat, input bit hold);
    exp_t e;
    @(negedge clk);
    drive(d, 1'b1, dat);
    @(posedge clk);
    e.data = dat;
    e.par  = (^dat) ^ ((d == 1) ? 1'b1 : 1'b0);
    sb_q.push_back(e);
    #1;
    if (!hold) drive(d, 1'b0, ~dat);
  endtask

  // Follow one frame from the cycle after acceptance (c=0) until tx_done.
  // Reassembles the data byte from data_bit, samples parity in the parity
  // slot and counts cycles whose sel/busy/data_bit disagree with the frame
  // layout. Optionally pulses tx_start with inj_data at cycle inj_c.
  task automatic capture_frame(input int d, input int inj_c, input logic [7:0] inj_data,
                               output logic [7:0] got_data, output logic got_par,
                               output int got_len, output int seq_err);
    int cpb;
    logic [1:0] s, exp_s;
    logic db, pb, busy, done;
    cpb      = (d == 2) ? 2 : 4;
    got_data = 8'hxx;
    got_par  = 1'bx;
    got_len  = -1;
    seq_err  = 0;
    for (int c = 0; c < 200 && got_len < 0; c++) begin
      @(negedge clk);
      sample(d, s, db, pb, busy, done);
      if (inj_c >= 0 && c == inj_c) drive(d, 1'b1, inj_data);
      else if (inj_c >= 0 && c == inj_c + 1) drive(d, 1'b0, 8'h00);
      if (done === 1'b1) begin
        got_len = c;
        if (busy !== 1'b0 || s !== 2'b11) seq_err++;
      end else begin
        if (c < cpb) exp_s = 2'b00;
        else if (c < 9 * cpb) exp_s = 2'b01;
        else if (c < 10 * cpb) exp_s = 2'b10;
        else exp_s = 2'b11;
        if (s !== exp_s || busy !== 1'b1) seq_err++;
        if (exp_s == 2'b01) begin
          int k;
          k = (c - cpb) / cpb;
          if ((c - cpb) % cpb == 0) got_data[k] = db;
          else if (got_data[k] !== db) seq_err++;
        end
        if (exp_s == 2'b10) got_par = pb;
      end
    end
  endtask

  task automatic test_reset();
    logic [1:0] s;
    logic db, pb, busy, done;
    rst = 1'b1;
    drive(0, 1'b1, 8'hA5);
    drive(1, 1'b1, 8'hA5);
    drive(2, 1'b1, 8'hA5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample(0, s, db, pb, busy, done);
    tests_run++;
    if ({s, db, pb, busy, done} !== 6'b110000) begin
      tests_failed++;
      $display("FAIL reset_state: got sel=%b db=%b pb=%b busy=%b done=%b, want 11 0 0 0 0",
               s, db, pb, busy, done);
    end
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sample(d, s, db, pb, busy, done);
      tests_run++;
      if (s !== 2'b11 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL start_during_reset[%0d]: got sel=%b busy=%b, want 11 0", d, s, busy);
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] gd;
    logic gp;
    int len, serr;
    exp_t e;
    start_frame(0, 8'hA5, 1'b0);
    capture_frame(0, -1, 8'h00, gd, gp, len, serr);
    e = pop_exp();
    tests_run += 4;
    if (gd !== e.data) begin tests_failed++; $display("FAIL a5_data: got %h want %h", gd, e.data); end
    if (gp !== e.par) begin tests_failed++; $display("FAIL a5_parity: got %b want %b", gp, e.par); end
    if (len !== 44) begin tests_failed++; $display("FAIL a5_done_cycle: got %0d want 44", len); end
    if (serr !== 0) begin tests_failed++; $display("FAIL a5_sequence: got %0d bad cycles want 0", serr); end
  endtask

  task automatic test_parity();
    logic [7:0] gd;
    logic gp;
    int len, serr;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      start_frame(d, 8'h07, 1'b0);
      capture_frame(d, -1, 8'h00, gd, gp, len, serr);
      e = pop_exp();
      tests_run += 3;
      if (gd !== e.data) begin tests_failed++; $display("FAIL parity07_data[%0d]: got %h want %h", d, gd, e.data); end
      if (gp !== e.par) begin tests_failed++; $display("FAIL parity07_bit[%0d]: got %b want %b", d, gp, e.par); end
      if (len !== 44 || serr !== 0) begin
        tests_failed++;
        $display("FAIL parity07_frame[%0d]: got len=%0d bad=%0d want 44 0", d, len, serr);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] gd;
    logic gp;
    int len, serr, extra;
    logic [1:0] s;
    logic db, pb, busy, done;
    exp_t e;
    start_frame(0, 8'h00, 1'b0);
    capture_frame(0, 12, 8'hFF, gd, gp, len, serr);
    e = pop_exp();
    tests_run += 3;
    if (gd !== e.data || gp !== e.par) begin
      tests_failed++;
      $display("FAIL busy_ignore_data: got %h/%b want %h/%b", gd, gp, e.data, e.par);
    end
    if (len !== 44 || serr !== 0) begin
      tests_failed++;
      $display("FAIL busy_ignore_frame: got len=%0d bad=%0d want 44 0", len, serr);
    end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sample(0, s, db, pb, busy, done);
      if (s !== 2'b11 || busy !== 1'b0 || done !== 1'b0) extra++;
    end
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL busy_ignore_no_second: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] gd;
    logic gp;
    int len, serr;
    exp_t e;
    exp_t e2;
    start_frame(0, 8'h3C, 1'b1);
    drive(0, 1'b1, 8'hC3);
    capture_frame(0, -1, 8'h00, gd, gp, len, serr);
    e = pop_exp();
    tests_run += 2;
    if (gd !== e.data || gp !== e.par) begin
      tests_failed++;
      $display("FAIL b2b_first_data: got %h/%b want %h/%b", gd, gp, e.data, e.par);
    end
    if (len !== 44 || serr !== 0) begin
      tests_failed++;
      $display("FAIL b2b_first_frame: got len=%0d bad=%0d want 44 0", len, serr);
    end
    e2.data = 8'hC3;
    e2.par  = ^e2.data;
    sb_q.push_back(e2);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'h00);
    capture_frame(0, -1, 8'h00, gd, gp, len, serr);
    e = pop_exp();
    tests_run += 2;
    if (gd !== e.data || gp !== e.par) begin
      tests_failed++;
      $display("FAIL b2b_second_data: got %h/%b want %h/%b", gd, gp, e.data, e.par);
    end
    if (len !== 44 || serr !== 0) begin
      tests_failed++;
      $display("FAIL b2b_second_frame: got len=%0d bad=%0d want 44 0", len, serr);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] gd;
    logic gp;
    int len, serr;
    logic [1:0] s;
    logic db, pb, busy, done;
    exp_t e;
    start_frame(0, 8'h96, 1'b0);
    e = pop_exp();
    repeat (38) @(negedge clk);
    sample(0, s, db, pb, busy, done);
    tests_run++;
    if (s !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_mid_in_parity: got sel=%b want 10", s);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample(0, s, db, pb, busy, done);
    tests_run++;
    if ({s, db, pb, busy, done} !== 6'b110000) begin
      tests_failed++;
      $display("FAIL rst_mid_state: got sel=%b db=%b pb=%b busy=%b done=%b, want 11 0 0 0 0",
               s, db, pb, busy, done);
    end
    start_frame(0, 8'h5A, 1'b0);
    capture_frame(0, -1, 8'h00, gd, gp, len, serr);
    e = pop_exp();
    tests_run += 2;
    if (gd !== e.data || gp !== e.par) begin
      tests_failed++;
      $display("FAIL rst_mid_next_data: got %h/%b want %h/%b", gd, gp, e.data, e.par);
    end
    if (len !== 44 || serr !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_next_frame: got len=%0d bad=%0d want 44 0", len, serr);
    end
  endtask

  task automatic test_short_bit();
    logic [7:0] gd;
    logic gp;
    int len, serr;
    exp_t e;
    start_frame(2, 8'h80, 1'b0);
    capture_frame(2, -1, 8'h00, gd, gp, len, serr);
    e = pop_exp();
    tests_run += 3;
    if (gd !== e.data || gp !== e.par) begin
      tests_failed++;
      $display("FAIL cpb2_data: got %h/%b want %h/%b", gd, gp, e.data, e.par);
    end
    if (len !== 22) begin tests_failed++; $display("FAIL cpb2_length: got %0d want 22", len); end
    if (serr !== 0) begin tests_failed++; $display("FAIL cpb2_sequence: got %0d bad cycles want 0", serr); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    test_reset();
    test_basic_frame();
    test_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_short_bit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 868: clk cycles per serial bit; legal range 2..65535.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 tx_start  input  1  request to send tx_data; sampled only in IDLE.
REQ-007 tx_data  input  DATA_WIDTH  byte to transmit; captured in the cycle tx_start is accepted.
REQ-008 sel  output  2  bit-type select to the downstream 4:1 output mux: 00 start, 01 data, 10 parity, 11 stop/idle.
REQ-009 data_bit  output  1  current data bit, LSB first; drives mux data input.
REQ-010 parity_bit  output  1  parity of the captured byte; drives mux parity input.
REQ-011 tx_busy  output  1  high from acceptance until the frame ends.
REQ-012 tx_done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; sel SHALL be 11 in IDLE and STOP, 00 in START, 01 in DATA, 10 in PARITY, driven from registered state only.
REQ-014 In IDLE with tx_start=1, the block SHALL capture tx_data into a shift register, compute parity_bit (XOR reduction, inverted when PARITY_ODD=1), and enter START on the next edge.
REQ-015 START, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles; DATA SHALL last DATA_WIDTH*CLKS_PER_BIT cycles.
REQ-016 A baud counter SHALL reset to 0 on every state entry and at each bit boundary; a bit ends when the counter reaches CLKS_PER_BIT-1.
REQ-017 In DATA, data_bit SHALL present shift-register bit 0; the register SHALL shift right by one at each data-bit boundary; a bit index counter (0..DATA_WIDTH-1) SHALL select the DATA->PARITY transition after index DATA_WIDTH-1.
REQ-018 Total frame length from the START entry edge to the IDLE return edge SHALL be (DATA_WIDTH+3)*CLKS_PER_BIT cycles.
REQ-019 tx_busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-020 On the STOP->IDLE edge, tx_done SHALL be 1 for exactly the first IDLE cycle.
REQ-021 tx_start while tx_busy=1 SHALL be ignored, with no queuing and no corruption of the frame in flight.
REQ-022 tx_start asserted in the cycle tx_done=1 SHALL be accepted (back-to-back frames, zero idle gap beyond that cycle).
REQ-023 tx_data changes after capture SHALL NOT affect data_bit or parity_bit for the current frame.
REQ-024 parity_bit and data_bit SHALL hold their last values outside the states that use them (no glitching required, value don't-care to the mux).

Reset
REQ-025 rst=1 at any clock edge, including mid-frame, SHALL force IDLE on that edge: sel=11, tx_busy=0, tx_done=0, data_bit=0, parity_bit=0, counters=0, shift register=0.
REQ-026 tx_start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-027 A shared package uart_pkg SHALL hold the sel encodings (START_BIT=00, DATA_BIT=01, PARITY_BIT=10, STOP_BIT=11) used by both this block and the output mux, plus the FSM state encoding.
REQ-028 The baud counter SHALL be a sub-module uart_baud_cnt with inputs clk, rst, clear and output bit_end, parameterised by CLKS_PER_BIT.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4 unless noted)
REQ-029 Send 0xA5, even parity: sel sequence 00x4, 01x32, 10x4, 11x4; data_bit pattern 1,0,1,0,0,1,0,1 (4 cycles each); parity_bit=0; tx_done pulses at cycle 44 after acceptance.
REQ-030 Send 0x07 with PARITY_ODD=0, then with PARITY_ODD=1: parity_bit=1, then 0.
REQ-031 Pulse tx_start with 0xFF during the DATA state of a 0x00 frame: frame stays all-zero data, no second frame starts.
REQ-032 Hold tx_start high with 0x3C then 0xC3 presented on tx_done: second START begins on the edge after tx_done, both frames are correct, and idle time is 1 cycle.
REQ-033 Assert rst for 1 cycle during PARITY: next cycle sel=11, tx_busy=0, tx_done=0; a new 0x5A frame afterwards is correct.
REQ-034 With CLKS_PER_BIT=2, send 0x80: frame lasts 22 cycles and the MSB appears only in data slot 7.
